m_lsu_bus: RTL and testbench

- Memory-stage load/store unit that narrows and widens data for the system bus.
- Store side: narrows 32-bit store data into a word-aligned bus write with byte enables.
- Load side: pulls a byte, halfword or word out of the returned bus word, then sign- or zero-extends it to 32 bits.
- Sits between the M-stage pipeline register and the system bridge. Runs a request/acknowledge handshake so variable-latency devices (DM, timers, peripherals) stall the pipeline through `busy`.

---
 rtl/m_lsu_bus.sv | 206 ++++++++++++++++++++
 tb/tb_m_lsu_bus.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/m_lsu_bus.sv
// Memory-stage load/store unit: narrows stores and extends loads around a req/ack bus handshake.
// Optional LSU_TIMEOUT_EN aborts a bus request that is not acknowledged within TIMEOUT cycles.
module m_lsu_bus #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic [4:0]  exc,
    output logic        bus_req,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    // state   | meaning
    // IDLE    | waiting for start from the M stage
    // REQ     | bus request outstanding, waiting for bus_ack
    // DONE    | one-cycle completion, done and exc valid
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [3:0] OP_LW  = 4'd0;
    localparam logic [3:0] OP_LH  = 4'd1;
    localparam logic [3:0] OP_LHU = 4'd2;
    localparam logic [3:0] OP_LB  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SB  = 4'd10;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;

    if (TIMEOUT < 2) begin : g_timeout_check
        $error("m_lsu_bus: TIMEOUT must be at least 2");
    end

    logic [1:0]  state_q;
    logic [3:0]  op_q;
    logic [1:0]  addr_lo_q;
    logic [31:0] rdata_q;
    logic [4:0]  exc_q;
    logic [31:0] bus_addr_q;
    logic [3:0]  bus_be_q;
    logic [31:0] bus_wdata_q;

    logic        op_legal;
    logic        op_load;
    logic        op_misal;
    logic [3:0]  be_n;
    logic [31:0] wd_n;

    logic [15:0] half_sel;
    logic [7:0]  byte_sel;
    logic [31:0] ld_ext;

    // Decode of the incoming request, only consumed in IDLE.
    always_comb begin
        op_legal = 1'b1;
        op_load  = 1'b0;
        op_misal = 1'b0;
        be_n     = 4'b0000;
        wd_n     = 32'h0;
        case (op)
            OP_LW: begin
                op_load  = 1'b1;
                op_misal = (addr[1:0] != 2'b00);
            end
            OP_LH, OP_LHU: begin
                op_load  = 1'b1;
                op_misal = addr[0];
            end
            OP_LB, OP_LBU: begin
                op_load  = 1'b1;
            end
            OP_SW: begin
                op_misal = (addr[1:0] != 2'b00);
                be_n     = 4'b1111;
                wd_n     = wdata;
            end
            OP_SH: begin
                op_misal = addr[0];
                be_n     = addr[1] ? 4'b1100 : 4'b0011;
                wd_n     = {2{wdata[15:0]}};
            end
            OP_SB: begin
                be_n     = 4'b0001 << addr[1:0];
                wd_n     = {4{wdata[7:0]}};
            end
            default: begin
                op_legal = 1'b0;
            end
        endcase
    end

    // Lane selection and extension of the returned bus word.
    always_comb begin
        half_sel = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (addr_lo_q)
            2'd0:    byte_sel = bus_rdata[7:0];
            2'd1:    byte_sel = bus_rdata[15:8];
            2'd2:    byte_sel = bus_rdata[23:16];
            default: byte_sel = bus_rdata[31:24];
        endcase
        case (op_q)
            OP_LH:   ld_ext = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  ld_ext = {16'h0, half_sel};
            OP_LB:   ld_ext = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  ld_ext = {24'h0, byte_sel};
            default: ld_ext = bus_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TMO_LOAD = CW'(TIMEOUT - 1);

    // Down-counter loaded on REQ entry; terminal count 0 ends the final REQ cycle.
    logic [CW-1:0] tmo_cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= 4'h0;
            addr_lo_q   <= 2'b00;
            rdata_q     <= 32'h0;
            exc_q       <= EXC_NONE;
            bus_addr_q  <= 32'h0;
            bus_be_q    <= 4'b0000;
            bus_wdata_q <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (!op_legal) begin
                            exc_q   <= EXC_RI;
                            state_q <= ST_DONE;
                        end else if (op_misal) begin
                            exc_q   <= op_load ? EXC_ADEL : EXC_ADES;
                            state_q <= ST_DONE;
                        end else begin
                            op_q        <= op;
                            addr_lo_q   <= addr[1:0];
                            bus_addr_q  <= {addr[31:2], 2'b00};
                            bus_be_q    <= be_n;
                            bus_wdata_q <= wd_n;
                            exc_q       <= EXC_NONE;
`ifdef LSU_TIMEOUT_EN
                            tmo_cnt_q   <= TMO_LOAD;
`endif
                            state_q     <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (bus_ack) begin
                        if (!op_q[3]) begin
                            rdata_q <= ld_ext;
                        end
                        state_q <= ST_DONE;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (tmo_cnt_q == '0) begin
                        exc_q   <= op_q[3] ? EXC_ADES : EXC_ADEL;
                        state_q <= ST_DONE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q - 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = (state_q == ST_REQ) || (state_q == ST_DONE);
    assign done      = (state_q == ST_DONE);
    assign bus_req   = (state_q == ST_REQ);
    assign rdata     = rdata_q;
    assign exc       = exc_q;
    assign bus_addr  = bus_addr_q;
    assign bus_be    = bus_be_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_m_lsu_bus.sv
// Directed bench for m_lsu_bus: loads, stores, faults, stalls and reset abort.
// Timeout steps are compiled in when LSU_TIMEOUT_EN is defined.
module tb_m_lsu_bus;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic [4:0]  exc;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int checks = 0;
    int errors = 0;

    m_lsu_bus #(.TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .rdata     (rdata),
        .exc       (exc),
        .bus_req   (bus_req),
        .bus_addr  (bus_addr),
        .bus_be    (bus_be),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_rdata (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d);
        start = 1'b1;
        op    = o;
        addr  = a;
        wdata = d;
        tick();
        start = 1'b0;
    endtask

    // Ack in the current REQ cycle and step into DONE.
    task automatic ack(input logic [31:0] d);
        bus_ack   = 1'b1;
        bus_rdata = d;
        tick();
        bus_ack   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'h0; addr = 32'h0; wdata = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_exc", exc, 0);
        chk("rst_req", bus_req, 0);
        chk("rst_addr", bus_addr, 0);
        chk("rst_be", bus_be, 0);
        chk("rst_wdata", bus_wdata, 0);

        // LB from byte 3, negative
        issue(4'd3, 32'h0000_3003, 32'h0);
        chk("lb_req", bus_req, 1);
        chk("lb_busy", busy, 1);
        chk("lb_done_early", done, 0);
        chk("lb_addr", bus_addr, 32'h0000_3000);
        chk("lb_be", bus_be, 4'b0000);
        ack(32'h80FF_1234);
        chk("lb_done", done, 1);
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_exc", exc, 0);
        chk("lb_req_drop", bus_req, 0);
        // start during DONE is ignored
        start = 1'b1; op = 4'd0; addr = 32'h0;
        tick();
        start = 1'b0;
        chk("done_start_ign_busy", busy, 0);
        chk("done_start_ign_req", bus_req, 0);
        chk("done_once", done, 0);

        issue(4'd2, 32'h0000_0012, 32'h0);
        ack(32'h8001_7FFF);
        chk("lhu_rdata", rdata, 32'h0000_8001);
        tick();
        issue(4'd1, 32'h0000_0010, 32'h0);
        ack(32'h8001_7FFF);
        chk("lh_rdata", rdata, 32'h0000_7FFF);
        tick();
        issue(4'd1, 32'h0000_0012, 32'h0);
        ack(32'h8001_7FFF);
        chk("lh_neg_rdata", rdata, 32'hFFFF_8001);
        tick();
        issue(4'd0, 32'h0000_0004, 32'h0);
        ack(32'hCAFE_F00D);
        chk("lw_rdata", rdata, 32'hCAFE_F00D);
        tick();
        issue(4'd4, 32'h0000_0023, 32'h0);
        ack(32'h80FF_1234);
        chk("lbu_rdata", rdata, 32'h0000_0080);
        tick();

        // SB with a 5-cycle stall
        issue(4'd10, 32'h0000_0102, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            bus_ack = 1'b0;
            chk("sb_stall_req", bus_req, 1);
            chk("sb_stall_addr", bus_addr, 32'h0000_0100);
            chk("sb_stall_be", bus_be, 4'b0100);
            chk("sb_stall_wdata", bus_wdata, 32'hEFEF_EFEF);
            chk("sb_stall_done", done, 0);
            tick();
        end
        ack(32'h1111_2222);
        chk("sb_done", done, 1);
        chk("sb_exc", exc, 0);
        chk("sb_rdata_kept", rdata, 32'h0000_0080);
        tick();
        issue(4'd9, 32'h0000_0102, 32'hDEAD_BEEF);
        chk("sh_be", bus_be, 4'b1100);
        chk("sh_wdata", bus_wdata, 32'hBEEF_BEEF);
        ack(32'h0);
        tick();
        issue(4'd9, 32'h0000_0200, 32'h1234_5678);
        chk("sh_lo_be", bus_be, 4'b0011);
        chk("sh_lo_wdata", bus_wdata, 32'h5678_5678);
        ack(32'h0);
        tick();
        issue(4'd8, 32'h0000_0008, 32'h1234_5678);
        chk("sw_be", bus_be, 4'b1111);
        chk("sw_wdata", bus_wdata, 32'h1234_5678);
        ack(32'h0);
        chk("sw_done", done, 1);
        tick();

        // Faults: no bus access, done next cycle
        issue(4'd0, 32'h0000_0006, 32'h0);
        chk("lw_mis_req", bus_req, 0);
        chk("lw_mis_done", done, 1);
        chk("lw_mis_exc", exc, 5'd4);
        chk("lw_mis_rdata", rdata, 32'h0000_0080);
        tick();
        issue(4'd9, 32'h0000_0005, 32'h0);
        chk("sh_mis_req", bus_req, 0);
        chk("sh_mis_done", done, 1);
        chk("sh_mis_exc", exc, 5'd5);
        tick();
        issue(4'd7, 32'h0000_0000, 32'h0);
        chk("ri_req", bus_req, 0);
        chk("ri_done", done, 1);
        chk("ri_exc", exc, 5'd10);
        chk("ri_rdata", rdata, 32'h0000_0080);
        tick();
        issue(4'd1, 32'h0000_0003, 32'h0);
        chk("lh_mis_exc", exc, 5'd4);
        tick();

        // Reset in the second REQ cycle of an SW
        issue(4'd8, 32'h0000_0040, 32'hA5A5_A5A5);
        tick();
        chk("rstreq_req_before", bus_req, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstreq_req", bus_req, 0);
        chk("rstreq_done", done, 0);
        chk("rstreq_busy", busy, 0);
        ack(32'h0);
        chk("late_ack_done", done, 0);
        chk("late_ack_busy", busy, 0);
        issue(4'd0, 32'h0000_0044, 32'h0);
        chk("post_rst_addr", bus_addr, 32'h0000_0044);
        ack(32'h1357_9BDF);
        chk("post_rst_done", done, 1);
        chk("post_rst_rdata", rdata, 32'h1357_9BDF);
        tick();

`ifdef LSU_TIMEOUT_EN
        issue(4'd8, 32'h0000_0080, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_req_last", bus_req, 1);
        tick();
        chk("tmo_req_drop", bus_req, 0);
        chk("tmo_done", done, 1);
        chk("tmo_exc", exc, 5'd5);
        tick();
        issue(4'd0, 32'h0000_0084, 32'h0);
        for (int i = 0; i < 15; i++) tick();
        ack(32'h2468_ACE0);
        chk("tmo_race_done", done, 1);
        chk("tmo_race_exc", exc, 0);
        chk("tmo_race_rdata", rdata, 32'h2468_ACE0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
